instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the multi-cycle pipelined RISC-V core; sits directly upstream of decode and drives the program memory's asynchronous read address. Holds the program counter, presents it to program memory, and captures the returned word into the IF/ID pipeline register with a valid bit. Handles decode stall, branch/jump redirect with flush, and halt detection (opcode `1111111`). Keeps a saturating fetch counter for bring-up.

## Interface
- `ADD_WIDTH`, 8: PC / program-memory address width (word-addressed).
- `WIDTH`, 32: instruction width.
- `CNT_WIDTH`, 16: fetch counter width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  decode cannot accept; hold PC and IF/ID.
- `branch_taken`  in  1  redirect request from execute, single-cycle pulse.
- `branch_target`  in  ADD_WIDTH  redirect word address.
- `add`  out  ADD_WIDTH  address to program memory (= PC register).
- `instruction`  in  WIDTH  program-memory read data, combinational from `add`.
- `if_id_instr`  out  WIDTH  registered instruction to decode.
- `if_id_pc`  out  ADD_WIDTH  address `if_id_instr` was fetched from.
- `if_id_valid`  out  1  `if_id_instr` is live.
- `halted`  out  1  fetch stopped on halt opcode.
- `fetch_count`  out  CNT_WIDTH  instructions captured with valid=1, saturating.

## Operation
- States: `RUN`, `HALT`. Reset enters `RUN`.
- Priority each edge: `branch_taken` > `stall` > normal fetch.
- `branch_taken` (any state, stall ignored): PC <= `branch_target`; `if_id_valid` <= 0 (flush); state <= `RUN`; `halted` <= 0; counter unchanged.
- `stall` (no branch): PC, IF/ID, state, counter all hold.
- `RUN`, no stall/branch: `if_id_instr` <= `instruction`, `if_id_pc` <= PC, `if_id_valid` <= 1, `fetch_count` += 1 (saturate at all-ones).
  - If `instruction[6:0]` == `1111111`: PC holds, state <= `HALT`, `halted` <= 1. Halt word itself is delivered to decode with valid=1.
  - Else PC <= PC + 1, modulo 2^ADD_WIDTH (255 -> 0 wraps silently).
- `HALT`, no stall/branch: `if_id_valid` <= 0, PC holds, counter holds. Exits only on `branch_taken` or reset.
- Branch arriving the same edge a halt word is on `instruction`: halt discarded, redirect wins, state stays `RUN`.

## Timing
- Reset values: PC=0, `add`=0, `if_id_instr`=0, `if_id_pc`=0, `if_id_valid`=0, `halted`=0, `fetch_count`=0, state=`RUN`.
- Reset asserted mid-operation: all of the above immediately (asynchronous), regardless of stall/branch.
- Fetch latency: word at `add` in cycle N appears on `if_id_instr` after edge N+1.
- Redirect penalty: one bubble; target word valid on `if_id_instr` two edges after the `branch_taken` edge.
- Steady state: one instruction per cycle when `stall`=0.
- `add` is a direct register output; no combinational path from any input to any output.

## Structure
- Shared package `riscv_pkg`: `OPCODE_HALT` = 7'b1111111, opcode field slice constants, `fetch_state_t` enum (`RUN`, `HALT`).
- Single flat module; no sub-module. Reusable for a later branch-predictor hook at the next-PC mux.

## Test plan
- Reset release with memory loaded `0x00800093`, `0x00200113`, ... -> edge 1: `if_id_instr`=0x00800093, `if_id_pc`=0, valid=1, `add`=1; edge 2: 0x00200113, pc 1; `fetch_count`=2.
- `stall` high for 3 cycles at PC=3 -> `add`, `if_id_*`, `fetch_count` frozen for 3 edges; resumes at PC=3 → 4 with no skipped or duplicated word.
- Halt word `0x0000007F` at address 9 -> `if_id_instr`=0x7F valid=1, `halted`=1, `add` stays 9, next edges valid=0, `fetch_count`=10 then constant.
- `branch_taken`=1 target=2 while PC=6 with `stall`=1 -> next edge `add`=2, valid=0; following edge `if_id_pc`=2 valid=1.
- In `HALT`, `branch_taken` target=0 -> `halted`=0, refetch from 0; separately branch coincident with halt word on `instruction` -> `halted` stays 0.
- Start at PC=255 via branch target 255 -> `if_id_pc`=255 then `add`=0; `rst_n` low mid-stream -> all outputs zero without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core front end.
//   OPC_LSB / OPC_MSB / OPC_WIDTH : position and width of the opcode field
//   OPCODE_HALT                   : opcode that stops instruction fetch
//   fetch_state_t                 : fetch-stage state (RUN / HALT)
//   is_halt_opcode()              : decodes the halt opcode from an opcode field
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int OPC_LSB   = 0;
    localparam int OPC_MSB   = 6;
    localparam int OPC_WIDTH = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_WIDTH-1:0] OPCODE_HALT = 7'b1111111;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // True when the opcode field is the halt opcode.
    function automatic logic is_halt_opcode(input logic [OPC_WIDTH-1:0] opcode);
        return (opcode == OPCODE_HALT);
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Instruction-fetch stage: holds the PC, drives the program-memory address,
// captures the returned word into the IF/ID register, and handles decode
// stall, branch redirect with flush, and halt detection.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   stall          in   decode cannot accept; PC and IF/ID hold
//   branch_taken   in   redirect request (single-cycle pulse), beats stall
//   branch_target  in   redirect word address
//   add            out  program-memory address (the PC register itself)
//   instruction    in   program-memory read data for add
//   if_id_instr    out  registered instruction to decode
//   if_id_pc       out  address if_id_instr was fetched from
//   if_id_valid    out  if_id_instr is live
//   halted         out  fetch stopped on the halt opcode
//   fetch_count    out  saturating count of words captured with valid=1
// -----------------------------------------------------------------------------
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int ADD_WIDTH = 8,
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [ADD_WIDTH-1:0] branch_target,
    output logic [ADD_WIDTH-1:0] add,
    input  logic [WIDTH-1:0]     instruction,
    output logic [WIDTH-1:0]     if_id_instr,
    output logic [ADD_WIDTH-1:0] if_id_pc,
    output logic                 if_id_valid,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    fetch_state_t         state_r;
    logic [ADD_WIDTH-1:0] pc_r;
    logic [WIDTH-1:0]     instr_r;
    logic [ADD_WIDTH-1:0] ipc_r;
    logic                 valid_r;
    logic                 halted_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    logic                 halt_word_s;
    logic [ADD_WIDTH-1:0] pc_seq_s;
    logic [CNT_WIDTH-1:0] cnt_next_s;

    // Halt detection on the word currently returned by program memory.
    assign halt_word_s = is_halt_opcode(instruction[OPC_MSB:OPC_LSB]);

    // Sequential next PC; wraps modulo 2^ADD_WIDTH. A future predictor would
    // replace this term at the next-PC mux below.
    assign pc_seq_s = pc_r + ADD_WIDTH'(1);

    // Saturating increment of the fetch counter.
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_r == {CNT_WIDTH{1'b1}}) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_WIDTH'(1);
        end
    end

    // Fetch FSM and IF/ID register: redirect beats stall beats normal fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RUN;
            pc_r     <= {ADD_WIDTH{1'b0}};
            instr_r  <= {WIDTH{1'b0}};
            ipc_r    <= {ADD_WIDTH{1'b0}};
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
            cnt_r    <= {CNT_WIDTH{1'b0}};
        end else if (branch_taken) begin
            // Redirect flushes IF/ID and cancels any halt, even one arriving now.
            pc_r     <= branch_target;
            valid_r  <= 1'b0;
            state_r  <= RUN;
            halted_r <= 1'b0;
        end else if (stall) begin
            pc_r     <= pc_r;
            valid_r  <= valid_r;
        end else begin
            case (state_r)
                RUN: begin
                    instr_r <= instruction;
                    ipc_r   <= pc_r;
                    valid_r <= 1'b1;
                    cnt_r   <= cnt_next_s;
                    if (halt_word_s) begin
                        // Halt word still goes to decode; PC parks on it.
                        state_r  <= HALT;
                        halted_r <= 1'b1;
                    end else begin
                        pc_r <= pc_seq_s;
                    end
                end
                HALT: begin
                    valid_r <= 1'b0;
                end
                default: begin
                    state_r <= RUN;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign add         = pc_r;
    assign if_id_instr = instr_r;
    assign if_id_pc    = ipc_r;
    assign if_id_valid = valid_r;
    assign halted      = halted_r;
    assign fetch_count = cnt_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. The stimulus process pushes the
// expected IF/ID captures (instruction, pc, fetch_count) into a queue; a
// separate monitor pops and compares on every edge that captured a new word.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic [AW-1:0] add;
    logic [DW-1:0] instruction;
    logic [DW-1:0] if_id_instr;
    logic [AW-1:0] if_id_pc;
    logic          if_id_valid;
    logic          halted;
    logic [CW-1:0] fetch_count;

    logic [DW-1:0] mem [0:255];
    exp_t          exp_q [$];
    int            n_total = 0;
    int            n_pass  = 0;
    logic          last_stall;
    logic          last_branch;
    logic          last_rst_n;

    assign instruction = mem[add];

    always #5 clk = ~clk;

    instruction_fetch #(.ADD_WIDTH(AW), .WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .add           (add),
        .instruction   (instruction),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push(input int a, input int c);
        exp_t e;
        e.instr = mem[a];
        e.pc    = AW'(a);
        e.cnt   = CW'(c);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: latch the controls seen by the coming edge, then check captures.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            last_stall  = stall;
            last_branch = branch_taken;
            last_rst_n  = rst_n;
            @(posedge clk);
            #1;
            if (last_rst_n && rst_n && !last_stall && !last_branch && if_id_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_capture: got pc %0d instr 0x%08h, none expected", if_id_pc, if_id_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr", if_id_instr, e.instr);
                    check("sb_pc", 32'(if_id_pc), 32'(e.pc));
                    check("sb_count", 32'(fetch_count), 32'(e.cnt));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    // Stimulus.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {12'(i), 20'h00013};
        end
        mem[0] = 32'h00800093;
        mem[1] = 32'h00200113;
        mem[9] = 32'h0000007F;

        // Reset state.
        #1;
        check("rst_add", 32'(add), 32'd0);
        check("rst_instr", if_id_instr, 32'd0);
        check("rst_pc", 32'(if_id_pc), 32'd0);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", 32'(fetch_count), 32'd0);

        // Release reset and fetch three words.
        push(0, 1); push(1, 2); push(2, 3);
        tick();
        rst_n = 1'b1;
        tick();
        check("edge1_add", 32'(add), 32'd1);
        tick();
        check("edge2_count", 32'(fetch_count), 32'd2);
        tick();
        check("run_add3", 32'(add), 32'd3);

        // Stall three edges at PC=3.
        stall = 1'b1;
        tick(); tick(); tick();
        check("stall_add", 32'(add), 32'd3);
        check("stall_count", 32'(fetch_count), 32'd3);
        check("stall_pc", 32'(if_id_pc), 32'd2);
        check("stall_valid", 32'(if_id_valid), 32'd1);
        stall = 1'b0;

        // Run to the halt word at 9.
        for (int a = 3; a <= 9; a++) push(a, a + 1);
        for (int k = 0; k < 7; k++) tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_add", 32'(add), 32'd9);
        check("halt_count", 32'(fetch_count), 32'd10);
        tick(); tick();
        check("halt_valid0", 32'(if_id_valid), 32'd0);
        check("halt_add_hold", 32'(add), 32'd9);
        check("halt_count_hold", 32'(fetch_count), 32'd10);

        // Branch out of HALT to 0.
        branch_taken = 1'b1; branch_target = 8'd0;
        tick();
        branch_taken = 1'b0;
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_valid", 32'(if_id_valid), 32'd0);
        check("unhalt_add", 32'(add), 32'd0);
        for (int a = 0; a <= 5; a++) push(a, a + 11);
        for (int k = 0; k < 6; k++) tick();
        check("pc6_add", 32'(add), 32'd6);

        // Branch with stall at PC=6, target 2.
        branch_taken = 1'b1; branch_target = 8'd2; stall = 1'b1;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        check("br_stall_add", 32'(add), 32'd2);
        check("br_stall_valid", 32'(if_id_valid), 32'd0);
        push(2, 17);
        tick();
        check("br_target_pc", 32'(if_id_pc), 32'd2);
        check("br_target_valid", 32'(if_id_valid), 32'd1);

        // Branch to 9, then branch coincident with the halt word there.
        branch_taken = 1'b1; branch_target = 8'd9;
        tick();
        check("br9_add", 32'(add), 32'd9);
        branch_target = 8'd255;
        tick();
        branch_taken = 1'b0;
        check("coinc_halted", 32'(halted), 32'd0);
        check("coinc_add", 32'(add), 32'd255);
        check("coinc_valid", 32'(if_id_valid), 32'd0);

        // Wrap from 255 to 0.
        push(255, 18); push(0, 19);
        tick();
        check("wrap_pc", 32'(if_id_pc), 32'd255);
        check("wrap_add", 32'(add), 32'd0);
        tick();
        check("wrap_add1", 32'(add), 32'd1);

        // Asynchronous reset mid-stream, away from a clock edge.
        stall = 1'b1;
        #4;
        rst_n = 1'b0;
        #1;
        check("arst_add", 32'(add), 32'd0);
        check("arst_instr", if_id_instr, 32'd0);
        check("arst_pc", 32'(if_id_pc), 32'd0);
        check("arst_valid", 32'(if_id_valid), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_count", 32'(fetch_count), 32'd0);
        tick(); tick();

        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL sb_drain: got %0d pending captures expected 0", exp_q.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
